// File: rtl/sd_response_receiver_pkg.sv
// Shared definitions for the SD response receiver.
// Holds the receiver FSM encoding, the CRC7 polynomial and the default
// frame geometry used by the top level, the interface and the CRC engine.
package sd_response_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECEIVE    = 2'd2,
    DONE       = 2'd3
  } rx_state_t;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift-out.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int DEFAULT_FRAME_WIDTH = 48;
  localparam int DEFAULT_TIMEOUT     = 64;
  localparam int DEFAULT_CNT_WIDTH   = 8;

endpackage

// File: rtl/sd_response_receiver_if.sv
// Host/line-side signal bundle of the SD response receiver.
// master: host controller / stimulus side (drives start_rx and serial_in).
// slave : the receiver (drives the frame and its status flags).
//   start_rx       arm pulse
//   serial_in      line bit from the PAD, idles high
//   response       received frame, MSB is the start bit
//   response_ready one-cycle completion/timeout pulse
//   crc_error, end_bit_error, timeout  sticky status until next arm
//   busy           receiver is waiting for or receiving a frame
interface sd_response_receiver_if #(
  parameter int FRAME_WIDTH = 48
) ();

  logic                   start_rx;
  logic                   serial_in;
  logic [FRAME_WIDTH-1:0] response;
  logic                   response_ready;
  logic                   crc_error;
  logic                   end_bit_error;
  logic                   timeout;
  logic                   busy;

  modport master (
    output start_rx, serial_in,
    input  response, response_ready, crc_error, end_bit_error, timeout, busy
  );

  modport slave (
    input  start_rx, serial_in,
    output response, response_ready, crc_error, end_bit_error, timeout, busy
  );

endinterface

// File: rtl/sd_response_receiver_crc7_serial.sv
// Bit-serial CRC7 engine (x^7+x^3+1, initial value 0), MSB-first.
// Ports:
//   Clock, Reset  clock and asynchronous active-low reset
//   Enable        advance (or clear) only when high; otherwise hold
//   clear         return the register to 0 (takes priority over bit_in)
//   bit_in        next message bit
//   crc           current remainder
module crc7_serial
  import sd_response_receiver_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       clear,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = bit_in ^ crc[6];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      crc <= 7'h00;
    end else if (Enable) begin
      if (clear) crc <= 7'h00;
      else       crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_response_receiver.sv
// SD response frame receiver.
// Once armed by start_rx it waits (bounded by TIMEOUT) for a start bit on
// serial_in, shifts in FRAME_WIDTH bits MSB-first, then checks the CRC7
// field and the end bit and pulses response_ready.
// Ports:
//   Clock, Reset  clock and asynchronous active-low reset
//   Enable        clock qualifier; all state holds while low
//   bus           sd_response_receiver_if slave modport (see interface)
module sd_response_receiver
  import sd_response_receiver_pkg::*;
#(
  parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input logic                  Clock,
  input logic                  Reset,
  input logic                  Enable,
  sd_response_receiver_if.slave bus
);

  // bcnt value while the end bit is on the line
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(FRAME_WIDTH - 1);
  // number of leading bits covered by the CRC
  localparam logic [CNT_WIDTH-1:0] CRC_BITS = CNT_WIDTH'(FRAME_WIDTH - 8);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);

  rx_state_t              state, state_next;
  logic [CNT_WIDTH-1:0]   bcnt, tcnt;
  logic [FRAME_WIDTH-1:0] response_q;
  logic                   ready_q, crc_err_q, end_err_q, timeout_q;
  logic [6:0]             crc;

  logic arm, start_seen, expire, wait_tick, shift, last_bit, crc_feed, busy;

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      state <= IDLE;
    else if (Enable) state <= state_next;
  end

  // Next-state logic; a start bit on the expiry edge wins over the timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start_rx) state_next = WAIT_START;
      WAIT_START: begin
        if (!bus.serial_in)     state_next = RECEIVE;
        else if (tcnt == TO_LAST) state_next = DONE;
      end
      RECEIVE:    if (bcnt == LAST_BIT) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    arm        = 1'b0;
    start_seen = 1'b0;
    expire     = 1'b0;
    wait_tick  = 1'b0;
    shift      = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: arm = Enable && bus.start_rx;
      WAIT_START: begin
        busy       = 1'b1;
        start_seen = Enable && !bus.serial_in;
        expire     = Enable && bus.serial_in && (tcnt == TO_LAST);
        wait_tick  = Enable && bus.serial_in && (tcnt != TO_LAST);
      end
      RECEIVE: begin
        busy     = 1'b1;
        shift    = Enable;
        last_bit = Enable && (bcnt == LAST_BIT);
      end
      default: ;
    endcase
    // incoming bit index is bcnt+1; only the leading CRC_BITS bits are covered
    crc_feed = start_seen || (shift && (bcnt < CRC_BITS));
  end

  // Frame shift register and bit counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      response_q <= '0;
      bcnt       <= '0;
    end else if (arm) begin
      response_q <= '0;
      bcnt       <= '0;
    end else if (start_seen) begin
      response_q <= {response_q[FRAME_WIDTH-2:0], bus.serial_in};
      bcnt       <= CNT_WIDTH'(1);
    end else if (shift) begin
      response_q <= {response_q[FRAME_WIDTH-2:0], bus.serial_in};
      bcnt       <= bcnt + CNT_WIDTH'(1);
    end
  end

  // Start-bit watchdog
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         tcnt <= '0;
    else if (arm)       tcnt <= '0;
    else if (wait_tick) tcnt <= tcnt + CNT_WIDTH'(1);
  end

  // Sticky status flags; on the end-bit edge response_q[6:0] holds the CRC field
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (arm) begin
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else if (expire) begin
      timeout_q <= 1'b1;
    end else if (last_bit) begin
      crc_err_q <= (crc != response_q[6:0]);
      end_err_q <= !bus.serial_in;
    end
  end

  // Completion pulse; it holds through Enable=0 so enabled logic sees it once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      ready_q <= 1'b0;
    else if (Enable) ready_q <= expire || last_bit;
  end

  crc7_serial u_crc7 (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (arm || crc_feed),
    .clear  (arm),
    .bit_in (bus.serial_in),
    .crc    (crc)
  );

  assign bus.response       = response_q;
  assign bus.response_ready = ready_q;
  assign bus.crc_error      = crc_err_q;
  assign bus.end_bit_error  = end_err_q;
  assign bus.timeout        = timeout_q;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_sd_response_receiver.sv
// Directed bench for sd_response_receiver: a table of frames with
// hand-computed status, plus sequences for timeout, start bit on the
// expiry edge, Enable gaps with an ignored mid-frame arm, and reset
// mid-frame.
module tb_sd_response_receiver;

  localparam int FW = 48;

  typedef struct {
    logic [FW-1:0] frame;
    logic          crc_err;
    logic          end_err;
    string         name;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   rdy_count = 0;

  always #5 clk = ~clk;

  sd_response_receiver_if #(.FRAME_WIDTH(FW)) bus ();

  sd_response_receiver #(
    .FRAME_WIDTH (FW),
    .TIMEOUT     (64),
    .CNT_WIDTH   (8)
  ) dut (
    .Clock  (clk),
    .Reset  (rst_n),
    .Enable (en),
    .bus    (bus)
  );

  always @(negedge clk) if (bus.response_ready === 1'b1) rdy_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm();
    @(negedge clk);
    bus.start_rx = 1'b1;
    @(negedge clk);
    bus.start_rx = 1'b0;
  endtask

  // Drives frame[hi] down to frame[lo], one enabled cycle per bit.
  task automatic send_bits(input logic [FW-1:0] frame, input int hi, input int lo,
                           input bit gaps, input bit mid_arm);
    for (int i = hi; i >= lo; i--) begin
      bus.serial_in = frame[i];
      if (gaps && (i % 3 == 0)) begin
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
      end
      bus.start_rx = mid_arm && (i == 25);
      @(negedge clk);
      bus.start_rx = 1'b0;
    end
    bus.serial_in = 1'b1;
  endtask

  task automatic rx_frame(input vec_t v, input bit gaps, input bit mid_arm);
    int base;
    base = rdy_count;
    arm();
    chk({v.name, " armed busy"}, 64'(bus.busy), 64'd1);
    chk({v.name, " armed response"}, 64'(bus.response), 64'd0);
    chk({v.name, " armed flags"},
        64'({bus.crc_error, bus.end_bit_error, bus.timeout}), 64'd0);
    repeat (5) @(negedge clk);
    send_bits(v.frame, FW - 1, 0, gaps, mid_arm);
    chk({v.name, " ready latency"}, 64'(bus.response_ready), 64'd1);
    chk({v.name, " response"}, 64'(bus.response), 64'(v.frame));
    chk({v.name, " crc_error"}, 64'(bus.crc_error), 64'(v.crc_err));
    chk({v.name, " end_bit_error"}, 64'(bus.end_bit_error), 64'(v.end_err));
    chk({v.name, " timeout"}, 64'(bus.timeout), 64'd0);
    chk({v.name, " busy low"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({v.name, " ready pulse end"}, 64'(bus.response_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk({v.name, " response held"}, 64'(bus.response), 64'(v.frame));
    chk({v.name, " ready count"}, 64'(rdy_count - base), 64'd1);
  endtask

  vec_t vecs[4];
  vec_t good;
  int   base;

  initial begin
    vecs[0] = '{frame: 48'h400000000095, crc_err: 1'b0, end_err: 1'b0, name: "good"};
    vecs[1] = '{frame: 48'h400000100095, crc_err: 1'b1, end_err: 1'b0, name: "crc_bad"};
    vecs[2] = '{frame: 48'h400000000094, crc_err: 1'b0, end_err: 1'b1, name: "end_bad"};
    vecs[3] = '{frame: 48'h400000000095, crc_err: 1'b0, end_err: 1'b0, name: "good_again"};
    good = vecs[0];

    bus.start_rx  = 1'b0;
    bus.serial_in = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset response", 64'(bus.response), 64'd0);
    chk("reset outputs",
        64'({bus.response_ready, bus.crc_error, bus.end_bit_error, bus.timeout, bus.busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 64'(bus.busy), 64'd0);

    // table-driven frames
    for (int k = 0; k < 4; k++) rx_frame(vecs[k], 1'b0, 1'b0);

    // timeout: no start bit for 64 cycles after arm
    base = rdy_count;
    arm();
    repeat (63) @(negedge clk);
    chk("to before expiry ready", 64'(bus.response_ready), 64'd0);
    chk("to before expiry flag", 64'(bus.timeout), 64'd0);
    chk("to before expiry busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("to ready", 64'(bus.response_ready), 64'd1);
    chk("to flag", 64'(bus.timeout), 64'd1);
    chk("to busy", 64'(bus.busy), 64'd0);
    chk("to response", 64'(bus.response), 64'd0);
    @(negedge clk);
    chk("to ready pulse end", 64'(bus.response_ready), 64'd0);
    chk("to flag sticky", 64'(bus.timeout), 64'd1);
    chk("to ready count", 64'(rdy_count - base), 64'd1);

    // start bit on the same edge the watchdog would expire
    base = rdy_count;
    arm();
    chk("race armed timeout cleared", 64'(bus.timeout), 64'd0);
    repeat (63) @(negedge clk);
    send_bits(good.frame, FW - 1, 0, 1'b0, 1'b0);
    chk("race ready", 64'(bus.response_ready), 64'd1);
    chk("race timeout", 64'(bus.timeout), 64'd0);
    chk("race response", 64'(bus.response), 64'(good.frame));
    chk("race crc_error", 64'(bus.crc_error), 64'd0);
    @(negedge clk);
    chk("race ready count", 64'(rdy_count - base), 64'd1);

    // Enable gaps plus an ignored arm mid-frame
    rx_frame('{frame: good.frame, crc_err: 1'b0, end_err: 1'b0, name: "gaps"}, 1'b1, 1'b1);

    // reset mid-frame, then a clean frame
    arm();
    send_bits(good.frame, FW - 1, FW - 20, 1'b0, 1'b0);
    chk("partial busy", 64'(bus.busy), 64'd1);
    chk("partial response", 64'(bus.response), 64'h40000);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset response", 64'(bus.response), 64'd0);
    chk("async reset outputs",
        64'({bus.response_ready, bus.crc_error, bus.end_bit_error, bus.timeout, bus.busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_frame('{frame: good.frame, crc_err: 1'b0, end_err: 1'b0, name: "after_reset"}, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
